// File: rtl/fwd_hazard_unit.sv
// Register-hazard tracking: owns EX/MEM destination slots, drives operand forwarding selects,
// the one-cycle load-use stall and a saturating stall counter. Option: FWD_ZERO_REG_GUARD_EN.
module fwd_hazard_unit #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned ZERO_REG = 31,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_rn_used,
  input  logic             id_rm_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [REG_W-1:0] ZeroReg = REG_W'(ZERO_REG);

`ifdef FWD_ZERO_REG_GUARD_EN
  localparam logic ZeroGuard = 1'b1;
`else
  localparam logic ZeroGuard = 1'b0;
`endif

  localparam logic [1:0] SelRf  = 2'b00;
  localparam logic [1:0] SelEx  = 2'b01;
  localparam logic [1:0] SelMem = 2'b10;

  logic             ex_valid_q, ex_reg_write_q, ex_mem_read_q;
  logic [REG_W-1:0] ex_rd_q;
  logic             mem_valid_q, mem_reg_write_q;
  logic [REG_W-1:0] mem_rd_q;
  logic [CNT_W-1:0] stall_count_q;

  logic ex_live, mem_live;
  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic load_use;

  // A slot can only source a hit if it really writes a register (and, when guarded, not XZR).
  assign ex_live  = ex_valid_q & ex_reg_write_q & ~(ZeroGuard & (ex_rd_q == ZeroReg));
  assign mem_live = mem_valid_q & mem_reg_write_q & ~(ZeroGuard & (mem_rd_q == ZeroReg));

  assign ex_hit_a  = ex_live & (ex_rd_q == id_rn) & id_rn_used & id_valid;
  assign ex_hit_b  = ex_live & (ex_rd_q == id_rm) & id_rm_used & id_valid;
  assign mem_hit_a = mem_live & (mem_rd_q == id_rn) & id_rn_used & id_valid;
  assign mem_hit_b = mem_live & (mem_rd_q == id_rm) & id_rm_used & id_valid;

  assign load_use = id_valid & ex_valid_q & ex_mem_read_q & ex_reg_write_q & (ex_hit_a | ex_hit_b);

  always_comb begin
    fwd_a = SelRf;
    fwd_b = SelRf;
    if (!load_use) begin
      if (ex_hit_a)       fwd_a = SelEx;
      else if (mem_hit_a) fwd_a = SelMem;
      if (ex_hit_b)       fwd_b = SelEx;
      else if (mem_hit_b) fwd_b = SelMem;
    end
  end

  assign stall       = load_use;
  assign stall_count = stall_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q      <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_rd_q         <= '0;
      mem_valid_q     <= 1'b0;
      mem_reg_write_q <= 1'b0;
      mem_rd_q        <= '0;
      stall_count_q   <= '0;
    end else begin
      mem_valid_q     <= ex_valid_q;
      mem_reg_write_q <= ex_reg_write_q;
      mem_rd_q        <= ex_rd_q;
      if (load_use || flush || !id_valid) begin
        ex_valid_q     <= 1'b0;
        ex_reg_write_q <= 1'b0;
        ex_mem_read_q  <= 1'b0;
        ex_rd_q        <= '0;
      end else begin
        ex_valid_q     <= 1'b1;
        ex_reg_write_q <= id_reg_write;
        ex_mem_read_q  <= id_mem_read;
        ex_rd_q        <= id_rd;
      end
      if (load_use && (stall_count_q != '1)) begin
        stall_count_q <= stall_count_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed instruction sequences, expectations queued by
// the driver and checked by an independent monitor; a CNT_W=2 copy checks counter saturation.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rn = '0, id_rm = '0, id_rd = '0;
  logic       id_rn_used = 1'b0, id_rm_used = 1'b0;
  logic       id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;

  logic        stall, stall2;
  logic [1:0]  fwd_a, fwd_b, fwd_a2, fwd_b2;
  logic [15:0] stall_count;
  logic [1:0]  stall_count2;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_W(5), .ZERO_REG(31), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_rn_used(id_rn_used), .id_rm_used(id_rm_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
  );

  fwd_hazard_unit #(.REG_W(5), .ZERO_REG(31), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_rn_used(id_rn_used), .id_rm_used(id_rm_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall2), .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall_count(stall_count2)
  );

  typedef struct {
    string      name;
    logic       st;
    logic [1:0] fa;
    logic [1:0] fb;
    int         cnt;
    int         cnt2;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic cmp(input string name, input string field, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s.%s: got %0d, expected %0d", name, field, act, req);
    end
  endtask

  // Monitor: consumes one queued expectation per sample request.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (exp_q.size() == 0) begin
        cmp("scoreboard", "underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        cmp(e.name, "stall", int'(stall), int'(e.st));
        cmp(e.name, "fwd_a", int'(fwd_a), int'(e.fa));
        cmp(e.name, "fwd_b", int'(fwd_b), int'(e.fb));
        cmp(e.name, "stall_count", int'(stall_count), e.cnt);
        cmp(e.name, "stall_count_sat", int'(stall_count2), e.cnt2);
      end
    end
  end

  task automatic issue(input logic v, input int rn, input int rm, input logic rnu,
                       input logic rmu, input int rd, input logic rw, input logic mr,
                       input logic fl);
    @(posedge clk);
    #1;
    id_valid = v; id_rn = 5'(rn); id_rm = 5'(rm); id_rn_used = rnu; id_rm_used = rmu;
    id_rd = 5'(rd); id_reg_write = rw; id_mem_read = mr; flush = fl;
  endtask

  task automatic expect_now(input string name, input logic st, input logic [1:0] fa,
                            input logic [1:0] fb, input int c, input int c2);
    exp_t e;
    e.name = name; e.st = st; e.fa = fa; e.fb = fb; e.cnt = c; e.cnt2 = c2;
    exp_q.push_back(e);
    ->sample_ev;
  endtask

  task automatic expect_at_negedge(input string name, input logic st, input logic [1:0] fa,
                                   input logic [1:0] fb, input int c, input int c2);
    @(negedge clk);
    expect_now(name, st, fa, fb, c, c2);
  endtask

  localparam logic [1:0] Rf = 2'b00, Ex = 2'b01, Mem = 2'b10;

  initial begin
    logic [1:0] zero_fa;
`ifdef FWD_ZERO_REG_GUARD_EN
    zero_fa = Rf;
`else
    zero_fa = Ex;
`endif
    #3 expect_now("reset", 1'b0, Rf, Rf, 0, 0);
    #5 reset_n = 1'b1;

    // ADD X1 then SUB reading X1 as Rn
    issue(1, 10, 11, 1, 1, 1, 1, 0, 0);  expect_at_negedge("add_x1", 0, Rf, Rf, 0, 0);
    issue(1, 1, 12, 1, 1, 6, 1, 0, 0);   expect_at_negedge("sub_rn_x1", 0, Ex, Rf, 0, 0);
    // ADD X2, unrelated, reader of X2 as Rm
    issue(1, 13, 14, 1, 1, 2, 1, 0, 0);  expect_at_negedge("add_x2", 0, Rf, Rf, 0, 0);
    issue(1, 15, 16, 1, 1, 7, 1, 0, 0);  expect_at_negedge("unrelated", 0, Rf, Rf, 0, 0);
    issue(1, 17, 2, 1, 1, 8, 1, 0, 0);   expect_at_negedge("rm_x2_mem", 0, Rf, Mem, 0, 0);
    // LDUR X3 then ADD reading X3
    issue(1, 18, 0, 1, 0, 3, 1, 1, 0);   expect_at_negedge("ldur_x3", 0, Rf, Rf, 0, 0);
    issue(1, 3, 19, 1, 1, 9, 1, 0, 0);   expect_at_negedge("load_use_x3", 1, Rf, Rf, 0, 0);
    issue(1, 3, 19, 1, 1, 9, 1, 0, 0);   expect_at_negedge("after_stall_x3", 0, Mem, Rf, 1, 1);
    // ADD X4 twice, then reader: EX beats MEM
    issue(1, 20, 21, 1, 1, 4, 1, 0, 0);  expect_at_negedge("add_x4_a", 0, Rf, Rf, 1, 1);
    issue(1, 22, 23, 1, 1, 4, 1, 0, 0);  expect_at_negedge("add_x4_b", 0, Rf, Rf, 1, 1);
    issue(1, 4, 4, 1, 1, 10, 1, 0, 0);   expect_at_negedge("ex_priority", 0, Ex, Ex, 1, 1);
    // Write X31 then reader of X31
    issue(1, 24, 25, 1, 1, 31, 1, 0, 0); expect_at_negedge("write_x31", 0, Rf, Rf, 1, 1);
    issue(1, 31, 26, 1, 1, 11, 1, 0, 0); expect_at_negedge("read_x31", 0, zero_fa, Rf, 1, 1);
    // LDUR X5 flushed, then reader of X5
    issue(1, 27, 0, 1, 0, 5, 1, 1, 1);   expect_at_negedge("ldur_x5_flush", 0, Rf, Rf, 1, 1);
    issue(1, 5, 5, 1, 1, 12, 1, 0, 0);   expect_at_negedge("after_flush", 0, Rf, Rf, 1, 1);
    // Three more load-use stalls: 16-bit counter reaches 4, 2-bit copy saturates at 3
    issue(1, 28, 0, 1, 0, 6, 1, 1, 0);   expect_at_negedge("ldur_x6", 0, Rf, Rf, 1, 1);
    issue(1, 29, 6, 1, 1, 13, 1, 0, 0);  expect_at_negedge("load_use_x6", 1, Rf, Rf, 1, 1);
    issue(1, 29, 6, 1, 1, 13, 1, 0, 0);  expect_at_negedge("after_x6", 0, Rf, Mem, 2, 2);
    issue(1, 30, 0, 1, 0, 7, 1, 1, 0);   expect_at_negedge("ldur_x7", 0, Rf, Rf, 2, 2);
    issue(1, 7, 0, 1, 1, 14, 1, 0, 0);   expect_at_negedge("load_use_x7", 1, Rf, Rf, 2, 2);
    issue(1, 7, 0, 1, 1, 14, 1, 0, 0);   expect_at_negedge("after_x7", 0, Mem, Rf, 3, 3);
    issue(1, 1, 0, 1, 0, 8, 1, 1, 0);    expect_at_negedge("ldur_x8", 0, Rf, Rf, 3, 3);
    issue(1, 8, 8, 1, 1, 15, 1, 0, 0);   expect_at_negedge("load_use_x8", 1, Rf, Rf, 3, 3);
    issue(1, 8, 8, 1, 1, 15, 1, 0, 0);   expect_at_negedge("sat_hold", 0, Mem, Mem, 4, 3);
    // Reset asserted mid-stall, checked before any further clock edge
    issue(1, 2, 0, 1, 0, 9, 1, 1, 0);    expect_at_negedge("ldur_x9", 0, Rf, Rf, 4, 3);
    issue(1, 9, 3, 1, 1, 16, 1, 0, 0);   expect_at_negedge("load_use_x9", 1, Rf, Rf, 4, 3);
    #1 reset_n = 1'b0;
    #1 expect_now("async_reset", 0, Rf, Rf, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    issue(1, 9, 3, 1, 1, 16, 1, 0, 0);   expect_at_negedge("post_reset", 0, Rf, Rf, 0, 0);

    #2;
    if (exp_q.size() != 0) cmp("scoreboard", "leftover", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
